// File: rtl/vedic_accum_seq.sv
// Sequential accumulator that forms the 128-bit product of the 64x64 Vedic multiplier
// from its four 32x32 partial products, using one time-shared 32-bit ripple adder.

module Full_Adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    always_comb begin : ripple
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the
// other side's signal in the same cycle.
module vedic_accum_seq #(
    parameter int ADD_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  q0,
    input  logic [63:0]  q1,
    input  logic [63:0]  q2,
    input  logic [63:0]  q3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] product,
    output logic         busy,
    output logic         ovf,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] CYC_LAST = 2'(ADD_CYCLES - 1);

    state_t       state, next_state;
    logic [63:0]  q0_r, q1_r, q2_r, q3_r;
    logic [127:0] acc;
    logic [127:0] op_full;
    logic [1:0]   pass, word, cyc;
    logic         carry, ovf_r;
    logic [31:0]  acc_word, op_word, sum_w;
    logic         cin_w, cout_w, last_cyc;

    // Operand for the current pass, already shifted into its 128-bit position.
    always_comb begin
        op_full = '0;
        case (pass)
            2'd0:    op_full = {64'b0, q0_r};
            2'd1:    op_full = {32'b0, q1_r, 32'b0};
            2'd2:    op_full = {32'b0, q2_r, 32'b0};
            default: op_full = {q3_r, 64'b0};
        endcase
    end

    assign acc_word = acc[{word, 5'b0} +: 32];
    assign op_word  = op_full[{word, 5'b0} +: 32];
    assign cin_w    = carry & (word != 2'd0);
    assign last_cyc = (cyc == CYC_LAST);

    Full_Adder_32bit u_adder (
        .a    (acc_word),
        .b    (op_word),
        .cin  (cin_w),
        .sum  (sum_w),
        .cout (cout_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = BEAT;
            BEAT:    if (last_cyc && pass == 2'd3 && word == 2'd3) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_r  <= '0;
            q1_r  <= '0;
            q2_r  <= '0;
            q3_r  <= '0;
            acc   <= '0;
            pass  <= '0;
            word  <= '0;
            cyc   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            q0_r  <= q0;
            q1_r  <= q1;
            q2_r  <= q2;
            q3_r  <= q3;
            acc   <= '0;
            pass  <= '0;
            word  <= '0;
            cyc   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == BEAT) begin
            if (last_cyc) begin
                cyc                     <= '0;
                acc[{word, 5'b0} +: 32] <= sum_w;
                if (word != 2'd3) begin
                    carry <= cout_w;
                    word  <= word + 2'd1;
                end else begin
                    // A carry out of the top word means the running sum passed 2^128.
                    ovf_r <= ovf_r | cout_w;
                    carry <= 1'b0;
                    word  <= '0;
                    pass  <= pass + 2'd1;
                end
            end else begin
                cyc <= cyc + 2'd1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BEAT) || (state == DONE);
    assign product   = acc;
    assign ovf       = ovf_r;
    assign state_dbg = state;
endmodule

// File: tb/tb_vedic_accum_seq.sv
// Bench for vedic_accum_seq: two instances (ADD_CYCLES=1 and 3), table vectors,
// hand-written reset/backpressure/busy sequences and random operations against a model.

module tb_vedic_accum_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid[2], in_ready[2], out_valid[2], out_ready[2], busy[2], ovf[2];
    logic [63:0]  q0[2], q1[2], q2[2], q3[2];
    logic [127:0] product[2];
    logic [1:0]   state_dbg[2];

    vedic_accum_seq #(.ADD_CYCLES(1)) u_ac1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .q0(q0[0]), .q1(q1[0]), .q2(q2[0]), .q3(q3[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .product(product[0]),
        .busy(busy[0]), .ovf(ovf[0]), .state_dbg(state_dbg[0])
    );

    vedic_accum_seq #(.ADD_CYCLES(3)) u_ac3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .q0(q0[1]), .q1(q1[1]), .q2(q2[1]), .q3(q3[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .product(product[1]),
        .busy(busy[1]), .ovf(ovf[1]), .state_dbg(state_dbg[1])
    );

    int total = 0;
    int bad   = 0;
    logic [128:0] exp_q[$];   // {ovf, product} expected per issued operation

    typedef struct {
        int           k;
        logic [63:0]  a0, a1, a2, a3;
        logic [127:0] p;
        logic         o;
        int           hold;
        bit           junk;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: add each shifted partial product into a 128-bit total, noting overflow.
    function automatic void ref_model(input logic [63:0] a0, a1, a2, a3,
                                      output logic [127:0] p, output logic o);
        logic [127:0] ops[4];
        logic [128:0] s;
        ops[0] = {64'b0, a0};
        ops[1] = {64'b0, a1} << 32;
        ops[2] = {64'b0, a2} << 32;
        ops[3] = {64'b0, a3} << 64;
        p = '0;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, p} + {1'b0, ops[i]};
            o = o | s[128];
            p = s[127:0];
        end
    endfunction

    task automatic run_op(input int k, input logic [63:0] a0, a1, a2, a3,
                          input int hold, input bit junk, input string tag);
        int           lat;
        int           exp_lat;
        bit           hs_bad;
        logic [127:0] held;
        logic [128:0] e;
        e       = exp_q.pop_front();
        exp_lat = (k == 0) ? 16 : 48;
        hs_bad  = 1'b0;
        @(posedge clk); #1;
        check({tag, " in_ready_idle"}, 128'(in_ready[k]), 128'd1);
        q0[k] = a0; q1[k] = a1; q2[k] = a2; q3[k] = a3;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b0;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 200) begin
            if (in_ready[k] || !busy[k]) hs_bad = 1'b1;
            if (junk && lat == 4) begin
                in_valid[k] = 1'b1;
                q0[k] = ~a0; q1[k] = ~a1; q2[k] = a2 ^ 64'h5a5a; q3[k] = ~a3;
            end
            if (junk && lat == 7) in_valid[k] = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        in_valid[k] = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " product"}, product[k], e[127:0]);
        check({tag, " ovf"}, 128'(ovf[k]), 128'(e[128]));
        held = product[k];
        for (int i = 0; i < hold; i++) begin
            if (junk && i == 0) in_valid[k] = 1'b1;
            @(posedge clk); #1;
            if (!out_valid[k] || in_ready[k] || !busy[k] || product[k] !== held || ovf[k] !== e[128])
                hs_bad = 1'b1;
        end
        in_valid[k] = 1'b0;
        check({tag, " busy_hold"}, 128'(hs_bad), 128'd0);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check({tag, " idle_after"}, {126'b0, in_ready[k], out_valid[k]}, 128'b10);
    endtask

    initial begin
        logic [127:0] mp;
        logic         mo;
        logic [31:0]  al, ah, bl, bh;
        logic [63:0]  r0, r1, r2, r3;
        int           k;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 0; out_ready[i] = 0;
            q0[i] = '0; q1[i] = '0; q2[i] = '0; q3[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d ctl", i),
                  {124'b0, in_ready[i], out_valid[i], busy[i], ovf[i]}, 128'b1000);
            check($sformatf("reset%0d product", i), product[i], 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        vt[0] = '{0, 64'd15, 64'd0, 64'd0, 64'd0, 128'd15, 1'b0, 0, 1'b0};
        vt[1] = '{0, 64'd0, 64'h8000000000000000, 64'h8000000000000000, 64'd0,
                  128'h00000001_00000000_00000000_00000000, 1'b0, 1, 1'b0};
        vt[2] = '{0, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001,
                  64'hFFFFFFFE00000001, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001, 1'b0, 0, 1'b0};
        vt[3] = '{1, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001,
                  64'hFFFFFFFE00000001, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001, 1'b0, 10, 1'b0};
        vt[4] = '{1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                  64'hFFFFFFFFFFFFFFFF, 128'h00000001_FFFFFFFF_FFFFFFFD_FFFFFFFF, 1'b1, 2, 1'b0};
        vt[5] = '{0, 64'h0123456789ABCDEF, 64'd0, 64'd0, 64'd0,
                  128'h00000000_00000000_01234567_89ABCDEF, 1'b0, 3, 1'b1};
        vt[6] = '{1, 64'd0, 64'd0, 64'd0, 64'h0000000100000002,
                  128'h00000001_00000002_00000000_00000000, 1'b0, 4, 1'b1};

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({vt[i].o, vt[i].p});
            run_op(vt[i].k, vt[i].a0, vt[i].a1, vt[i].a2, vt[i].a3, vt[i].hold, vt[i].junk,
                   $sformatf("vec%0d", i));
        end

        // Reset dropped into the middle of pass 2 on the single-cycle instance.
        @(posedge clk); #1;
        q0[0] = 64'hFFFFFFFE00000001; q1[0] = q0[0]; q2[0] = q0[0]; q3[0] = q0[0];
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("rst_mid busy_before", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid ctl_async", {124'b0, in_ready[0], out_valid[0], busy[0], ovf[0]}, 128'b1000);
        check("rst_mid product_async", product[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid in_ready_after", 128'(in_ready[0]), 128'd1);
        begin
            bit pulse = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid[0] || busy[0]) pulse = 1'b1;
            end
            check("rst_mid no_out_valid", 128'(pulse), 128'd0);
        end

        // Random operations: half legal products of random a,b, half arbitrary words.
        for (int n = 0; n < 16; n++) begin
            k = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                al = $urandom(); ah = $urandom(); bl = $urandom(); bh = $urandom();
                r0 = {32'b0, al} * {32'b0, bl};
                r1 = {32'b0, ah} * {32'b0, bl};
                r2 = {32'b0, al} * {32'b0, bh};
                r3 = {32'b0, ah} * {32'b0, bh};
            end else begin
                r0 = {$urandom(), $urandom()};
                r1 = {$urandom(), $urandom()};
                r2 = {$urandom(), $urandom()};
                r3 = {$urandom(), $urandom()};
            end
            ref_model(r0, r1, r2, r3, mp, mo);
            exp_q.push_back({mo, mp});
            run_op(k, r0, r1, r2, r3, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
